// File: rtl/nes_bus_pkg.sv
// Shared definitions for the NES CPU bus master: cycle encoding and NTSC/PAL timing constants.
package nes_bus_pkg;

    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_READ  = 2'd1,
        CYC_WRITE = 2'd2
    } cyc_e;

    localparam int          NTSC_CLK_DIV  = 12;
    localparam int          NTSC_M2_LOW   = 5;
    localparam int          PAL_CLK_DIV   = 16;
    localparam int          PAL_M2_LOW    = 6;
    localparam logic [15:0] DEF_IDLE_ADDR = 16'h0000;

    // /ROMSEL is the NAND of A15 and phi2, exactly as the 2A03 board decodes it.
    function automatic logic romsel_of(input logic a15, input logic m2);
        return ~(a15 & m2);
    endfunction

endpackage

// File: rtl/nes_cpu_phase_gen.sv
// CPU-cycle phase counter: free-running m2 with a fixed duty and a last-phase strobe.
module nes_cpu_phase_gen #(
    parameter int CLK_DIV = 12,
    parameter int M2_LOW  = 5
) (
    input  logic clk,
    input  logic rst,
    output logic m2,
    output logic m2_nxt,
    output logic last
);
    localparam int PH_W = $clog2(CLK_DIV);

    logic [PH_W-1:0] ph;
    logic [PH_W-1:0] ph_nxt;

    always_comb begin
        last   = (ph == PH_W'(CLK_DIV - 1));
        ph_nxt = last ? '0 : ph + 1'b1;
        m2_nxt = (ph_nxt >= PH_W'(M2_LOW));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph <= '0;
            m2 <= 1'b0;
        end else begin
            ph <= ph_nxt;
            m2 <= m2_nxt;
        end
    end

endmodule

// File: rtl/nes_cpu_bus_master.sv
// 2A03-style cartridge CPU bus master: one bus cycle per accepted request, idle reads otherwise.
module nes_cpu_bus_master
    import nes_bus_pkg::*;
#(
    parameter int          CLK_DIV   = NTSC_CLK_DIV,
    parameter int          M2_LOW    = NTSC_M2_LOW,
    parameter logic [15:0] IDLE_ADDR = DEF_IDLE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic        req_rw,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    input  logic        irq_n_in,
    output logic        irq_pending
);
    logic m2_nxt;
    logic last;

    nes_cpu_phase_gen #(
        .CLK_DIV (CLK_DIV),
        .M2_LOW  (M2_LOW)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .m2     (m2),
        .m2_nxt (m2_nxt),
        .last   (last)
    );

    cyc_e        cyc_q, cyc_d;
    logic        a15_q, a15_d;
    logic        cpu_rw_d;
    logic [14:0] cpu_addr_d;
    logic [7:0]  data_out_d;
    logic [7:0]  rdata_d;
    logic        rsp_valid_d;
    logic        romsel_d;
    logic        oe_d;

    // Requests are only taken at the cycle boundary, never while reset is held.
    assign req_ready = last & ~rst;

    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    always_comb begin
        cyc_d       = cyc_q;
        a15_d       = a15_q;
        cpu_rw_d    = cpu_rw;
        cpu_addr_d  = cpu_addr;
        data_out_d  = cpu_data_out;
        rdata_d     = rsp_rdata;
        rsp_valid_d = 1'b0;

        if (last) begin
            // Read data is captured on the edge that ends the cycle, while m2 is still high.
            if (cyc_q == CYC_READ) begin
                rsp_valid_d = 1'b1;
                rdata_d     = cpu_data_in;
            end
            if (req_valid && req_ready) begin
                cyc_d      = req_rw ? CYC_READ : CYC_WRITE;
                a15_d      = req_addr[15];
                cpu_addr_d = req_addr[14:0];
                cpu_rw_d   = req_rw;
                if (!req_rw) data_out_d = req_wdata;
            end else begin
                cyc_d      = CYC_IDLE;
                a15_d      = IDLE_ADDR[15];
                cpu_addr_d = IDLE_ADDR[14:0];
                cpu_rw_d   = 1'b1;
            end
        end

        romsel_d = romsel_of(a15_d, m2_nxt);
        oe_d     = (cyc_d == CYC_WRITE) && m2_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q        <= CYC_IDLE;
            a15_q        <= IDLE_ADDR[15];
            cpu_rw       <= 1'b1;
            cpu_addr     <= IDLE_ADDR[14:0];
            cpu_data_out <= 8'h00;
            cpu_data_oe  <= 1'b0;
            romsel       <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
        end else begin
            cyc_q        <= cyc_d;
            a15_q        <= a15_d;
            cpu_rw       <= cpu_rw_d;
            cpu_addr     <= cpu_addr_d;
            cpu_data_out <= data_out_d;
            cpu_data_oe  <= oe_d;
            romsel       <= romsel_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rdata_d;
        end
    end

    logic irq_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_meta    <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            irq_meta    <= ~irq_n_in;
            irq_pending <= irq_meta;
        end
    end

endmodule
